// File: rtl/manual_ctrl_pkg.sv
// manual_ctrl_pkg: shared state encoding, channel-select width helper and default parameters
package manual_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ANGLE, REFL, CONFIRM} state_t;
  localparam int DEF_NCH            = 4;
  localparam int DEF_ANGLE_W        = 5;
  localparam int DEF_ANGLE_MAX      = 24;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: one-register rising-edge detector for a bundle of synchronous buttons
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_edge
);
  logic [W-1:0] r_prev;
  // remember last cycle's button levels so a held button yields a single edge
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) r_prev <= '0;
    else        r_prev <= i_btn;
  assign o_edge = i_btn & ~r_prev;
endmodule

// File: rtl/manual_control_multi.sv
// manual_control_multi: operator-driven angle/reflector commit sequencer for NCH tracker channels
// Optional idle-step abort: define MANUAL_CTRL_TIMEOUT_EN to enable the timeout counter.
module manual_control_multi
  import manual_ctrl_pkg::*;
#(
  parameter  int NCH            = DEF_NCH,
  parameter  int ANGLE_W        = DEF_ANGLE_W,
  parameter  int ANGLE_MAX      = DEF_ANGLE_MAX,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int CH_W           = ch_w(NCH)
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   enable,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [ANGLE_W-1:0]     angle,
  input  logic                   refl,
  input  logic                   angle_set,
  input  logic                   refl_set,
  input  logic                   enter,
  input  logic                   cancel,
  output logic [NCH*ANGLE_W-1:0] angle_out,
  output logic [NCH-1:0]         refl_out,
  output logic                   busy,
  output logic                   done,
  output logic                   clamp_err,
  output logic                   timeout
);
  logic [3:0]             w_edge;
  logic                   w_clamp;
  logic                   w_abort;
  logic                   w_to;
  state_t                 r_state;
  logic [CH_W-1:0]        r_ch;
  logic [ANGLE_W-1:0]     r_stg_angle;
  logic                   r_stg_refl;
  logic                   r_stg_clamp;
  logic [NCH*ANGLE_W-1:0] r_angle_out;
  logic [NCH-1:0]         r_refl_out;
  logic                   r_done;
  logic                   r_clamp_err;

  btn_edge #(.W(4)) u_btn (
    .clk    (clk),
    .res_n  (res_n),
    .i_btn  ({cancel, enter, refl_set, angle_set}),
    .o_edge (w_edge)
  );

  assign w_clamp = angle > ANGLE_W'(ANGLE_MAX);
  assign w_abort = (r_state != IDLE) && (w_edge[3] || !enable);

`ifdef MANUAL_CTRL_TIMEOUT_EN
  logic        w_step;
  logic [31:0] r_cnt;
  logic        r_timeout;
  assign w_step = (r_state == ANGLE && w_edge[0]) || (r_state == REFL && w_edge[1]) ||
                  (r_state == CONFIRM && w_edge[2]);
  assign w_to   = (r_state != IDLE) && (r_cnt == 32'(TIMEOUT_CYCLES - 1));
  // idle-step counter restarts on every state change; timeout pulses only when it actually aborts
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (r_state == IDLE || w_abort || w_to || w_step) ? '0 : r_cnt + 32'd1;
      r_timeout <= w_to && !w_abort;
    end
  assign timeout = r_timeout;
`else
  assign w_to    = 1'b0;
  assign timeout = 1'b0;
`endif

  // sequencer: IDLE -> ANGLE -> REFL -> CONFIRM -> commit, aborts win over any step
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      r_state     <= IDLE;
      r_ch        <= '0;
      r_stg_angle <= '0;
      r_stg_refl  <= 1'b0;
      r_stg_clamp <= 1'b0;
      r_angle_out <= '0;
      r_refl_out  <= '0;
      r_done      <= 1'b0;
      r_clamp_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort || w_to) r_state <= IDLE;
      else
        case (r_state)
          IDLE:
            if (enable && 32'(ch_sel) < NCH) begin
              r_ch    <= ch_sel;
              r_state <= ANGLE;
            end
          ANGLE:
            if (w_edge[0]) begin
              r_stg_angle <= w_clamp ? ANGLE_W'(ANGLE_MAX) : angle;
              r_stg_clamp <= w_clamp;
              if (w_clamp) r_clamp_err <= 1'b1;
              r_state     <= REFL;
            end
          REFL:
            if (w_edge[1]) begin
              r_stg_refl <= refl;
              r_state    <= CONFIRM;
            end
          CONFIRM:
            if (w_edge[2]) begin
              for (int i = 0; i < NCH; i++)
                if (r_ch == CH_W'(i)) begin
                  r_angle_out[i*ANGLE_W +: ANGLE_W] <= r_stg_angle;
                  r_refl_out[i]                     <= r_stg_refl;
                end
              if (!r_stg_clamp) r_clamp_err <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          default: r_state <= IDLE;
        endcase
    end

  assign angle_out = r_angle_out;
  assign refl_out  = r_refl_out;
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign clamp_err = r_clamp_err;
endmodule

// File: tb/tb_manual_control_multi.sv
// tb_manual_control_multi: directed self-checking bench for manual_control_multi
module tb_manual_control_multi;
  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [4:0]  angle = '0;
  logic        refl = 1'b0;
  logic        angle_set = 1'b0, refl_set = 1'b0, enter = 1'b0, cancel = 1'b0;
  logic [19:0] angle_out;
  logic [3:0]  refl_out;
  logic        busy, done, clamp_err, timeout;
  int          checks = 0;
  int          passed = 0;

  manual_control_multi #(.NCH(4), .ANGLE_W(5), .ANGLE_MAX(24), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .ch_sel(ch_sel), .angle(angle), .refl(refl),
    .angle_set(angle_set), .refl_set(refl_set), .enter(enter), .cancel(cancel),
    .angle_out(angle_out), .refl_out(refl_out), .busy(busy), .done(done),
    .clamp_err(clamp_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input int b);
    case (b)
      0: angle_set = 1'b1;
      1: refl_set  = 1'b1;
      2: enter     = 1'b1;
      default: cancel = 1'b1;
    endcase
    tick();
    {angle_set, refl_set, enter, cancel} = '0;
  endtask

  task automatic start(input logic [1:0] ch);
    enable = 1'b1;
    ch_sel = ch;
    tick();
  endtask

  initial begin
    #12;
    chk("rst_angle", 32'(angle_out), 0);
    chk("rst_refl", 32'(refl_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {done, clamp_err, timeout}, 0);
    res_n = 1'b1;
    tick();
    // nominal commit on channel 2, with ch_sel moved mid-sequence
    start(2);
    chk("nom_busy", 32'(busy), 1);
    ch_sel = 2'd3;
    angle = 5'd13;
    press(0);
    refl = 1'b1;
    press(1);
    press(2);
    enable = 1'b0;
    chk("nom_done", 32'(done), 1);
    chk("nom_angle", 32'(angle_out), 32'h03400);
    chk("nom_refl", 32'(refl_out), 32'h4);
    tick();
    chk("nom_done_1cyc", 32'(done), 0);
    chk("nom_idle", 32'(busy), 0);
    // clamped angle on channel 0
    start(0);
    angle = 5'd30;
    press(0);
    chk("clamp_set", 32'(clamp_err), 1);
    refl = 1'b0;
    press(1);
    press(2);
    enable = 1'b0;
    chk("clamp_angle", 32'(angle_out), 32'h03418);
    chk("clamp_sticky", 32'(clamp_err), 1);
    tick();
    chk("clamp_hold", 32'(clamp_err), 1);
    // unclamped commit clears clamp_err
    start(0);
    angle = 5'd5;
    press(0);
    refl = 1'b1;
    press(1);
    press(2);
    enable = 1'b0;
    chk("clamp_clear", 32'(clamp_err), 0);
    chk("clamp2_angle", 32'(angle_out), 32'h03405);
    chk("clamp2_refl", 32'(refl_out), 32'h5);
    tick();
    // channel 1 committed to 7
    start(1);
    angle = 5'd7;
    press(0);
    refl = 1'b0;
    press(1);
    press(2);
    enable = 1'b0;
    chk("ch1_angle", 32'(angle_out), 32'h034E5);
    tick();
    // held angle_set produces one step; enter ignored in REFL
    start(3);
    angle = 5'd3;
    angle_set = 1'b1;
    repeat (10) tick();
    angle_set = 1'b0;
    press(2);
    chk("held_no_done", 32'(done), 0);
    chk("held_busy", 32'(busy), 1);
    chk("held_angle", 32'(angle_out), 32'h034E5);
    refl = 1'b0;
    press(1);
    press(2);
    enable = 1'b0;
    chk("held_done", 32'(done), 1);
    chk("held_commit", 32'(angle_out), 32'h1B4E5);
    tick();
    // cancel beats a simultaneous enter
    start(3);
    angle = 5'd9;
    press(0);
    refl = 1'b1;
    press(1);
    enter = 1'b1;
    cancel = 1'b1;
    tick();
    {enter, cancel} = '0;
    enable = 1'b0;
    chk("cxl_busy", 32'(busy), 0);
    chk("cxl_done", 32'(done), 0);
    chk("cxl_angle", 32'(angle_out), 32'h1B4E5);
    chk("cxl_refl", 32'(refl_out), 32'h5);
    tick();
    // idle wait in REFL
    start(0);
    angle = 5'd1;
    press(0);
`ifdef MANUAL_CTRL_TIMEOUT_EN
    repeat (7) tick();
    chk("to_pre_busy", 32'(busy), 1);
    chk("to_pre_pulse", 32'(timeout), 0);
    tick();
    enable = 1'b0;
    chk("to_busy", 32'(busy), 0);
    chk("to_pulse", 32'(timeout), 1);
    tick();
    chk("to_pulse_1cyc", 32'(timeout), 0);
`else
    repeat (100) tick();
    chk("noto_busy", 32'(busy), 1);
    chk("noto_pulse", 32'(timeout), 0);
    enable = 1'b0;
    tick();
    chk("noto_abort", 32'(busy), 0);
`endif
    chk("to_angle", 32'(angle_out), 32'h1B4E5);
    // async reset while in CONFIRM
    start(2);
    press(0);
    press(1);
    chk("ar_busy_pre", 32'(busy), 1);
    #2 res_n = 1'b0;
    #1;
    chk("ar_angle", 32'(angle_out), 0);
    chk("ar_refl", 32'(refl_out), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_flags", {done, clamp_err, timeout}, 0);
    res_n = 1'b1;
    enable = 1'b0;
    tick();
    chk("ar_post_busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
